systolic_result_readout: RTL and testbench

// Reader side of the output SRAM written by the systolic controller/array. On a tpu_done

---
 rtl/systolic_result_readout.sv | 131 +++++++++++++
 tb/tb_systolic_result_readout.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_result_readout.sv
// Reads every result row from the output SRAM after tpu_done, in ascending address order.
// Each row is streamed to the host one element at a time over a valid/ready handshake.
module systolic_result_readout #(
  parameter int ARRAY_SIZE    = 8,
  parameter int DATA_WIDTH    = 16,
  parameter int K_ACCUM_DEPTH = 8,
  parameter int DATA_SET      = 1,
  parameter int ADDR_WIDTH    = 7
) (
  input  logic                             clk,
  input  logic                             srst,
  input  logic                             tpu_done,
  output logic                             sram_rd_en,
  output logic [ADDR_WIDTH-1:0]            sram_rd_addr,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] sram_rd_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [ADDR_WIDTH-1:0]            out_row,
  output logic [$clog2(ARRAY_SIZE)-1:0]    out_col,
  output logic                             out_last,
  output logic                             busy,
  output logic                             readout_done
);

  localparam int NUM_ROWS  = (K_ACCUM_DEPTH + 1) * DATA_SET;
  localparam int COL_WIDTH = $clog2(ARRAY_SIZE);
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(NUM_ROWS - 1);
  localparam logic [COL_WIDTH-1:0]  LAST_COL = COL_WIDTH'(ARRAY_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_STREAM = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                           state;
  logic [ADDR_WIDTH-1:0]            row;
  logic [COL_WIDTH-1:0]             col;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] buffer;
  logic [COL_WIDTH-1:0]             col_next;
  logic [DATA_WIDTH-1:0]            elem_next;

  // Element that becomes visible after the current one is accepted
  always_comb begin
    col_next  = col + COL_WIDTH'(1);
    elem_next = buffer[col_next*DATA_WIDTH +: DATA_WIDTH];
  end

  // Readout sequencer; every output is a register updated alongside the state
  always_ff @(posedge clk) begin
    if (srst) begin
      state        <= S_IDLE;
      row          <= '0;
      col          <= '0;
      buffer       <= '0;
      sram_rd_en   <= 1'b0;
      sram_rd_addr <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_row      <= '0;
      out_col      <= '0;
      out_last     <= 1'b0;
      busy         <= 1'b0;
      readout_done <= 1'b0;
    end else begin
      sram_rd_en   <= 1'b0;
      readout_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tpu_done) begin
            state        <= S_REQ;
            row          <= '0;
            sram_rd_en   <= 1'b1;
            sram_rd_addr <= '0;
            busy         <= 1'b1;
          end
        end
        S_REQ: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          // SRAM data is valid exactly one cycle after the read strobe
          buffer    <= sram_rd_data;
          col       <= '0;
          out_valid <= 1'b1;
          out_data  <= sram_rd_data[DATA_WIDTH-1:0];
          out_row   <= row;
          out_col   <= '0;
          out_last  <= (row == LAST_ROW) && (LAST_COL == COL_WIDTH'(0));
          state     <= S_STREAM;
        end
        S_STREAM: begin
          if (out_ready) begin
            if (col != LAST_COL) begin
              col      <= col_next;
              out_col  <= col_next;
              out_data <= elem_next;
              out_last <= (row == LAST_ROW) && (col_next == LAST_COL);
            end else begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              if (row != LAST_ROW) begin
                row          <= row + ADDR_WIDTH'(1);
                sram_rd_en   <= 1'b1;
                sram_rd_addr <= row + ADDR_WIDTH'(1);
                state        <= S_REQ;
              end else begin
                readout_done <= 1'b1;
                state        <= S_DONE;
              end
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_result_readout.sv
// Bench for systolic_result_readout: two instances (2 rows and 4 rows) against a
// queue-based model of the expected element stream built straight from SRAM contents.
module tb_systolic_result_readout;

  localparam int AS = 4;
  localparam int DW = 16;
  localparam int AW = 7;
  localparam int CW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic srst, tpu_done1, tpu_done2, out_ready, sel;
  logic rd_en1, rd_en2, valid1, valid2, last1, last2, busy1, busy2, done1, done2;
  logic [AW-1:0] addr1, addr2, row1, row2;
  logic [CW-1:0] col1, col2;
  logic [DW-1:0] data1, data2;
  logic [AS*DW-1:0] rdata1, rdata2;
  logic [AS*DW-1:0] mem1 [0:1];
  logic [AS*DW-1:0] mem2 [0:3];

  systolic_result_readout #(.ARRAY_SIZE(AS), .DATA_WIDTH(DW), .K_ACCUM_DEPTH(1),
                            .DATA_SET(1), .ADDR_WIDTH(AW)) dut1 (
    .clk(clk), .srst(srst), .tpu_done(tpu_done1), .sram_rd_en(rd_en1),
    .sram_rd_addr(addr1), .sram_rd_data(rdata1), .out_valid(valid1),
    .out_ready(out_ready), .out_data(data1), .out_row(row1), .out_col(col1),
    .out_last(last1), .busy(busy1), .readout_done(done1));

  systolic_result_readout #(.ARRAY_SIZE(AS), .DATA_WIDTH(DW), .K_ACCUM_DEPTH(1),
                            .DATA_SET(2), .ADDR_WIDTH(AW)) dut2 (
    .clk(clk), .srst(srst), .tpu_done(tpu_done2), .sram_rd_en(rd_en2),
    .sram_rd_addr(addr2), .sram_rd_data(rdata2), .out_valid(valid2),
    .out_ready(out_ready), .out_data(data2), .out_row(row2), .out_col(col2),
    .out_last(last2), .busy(busy2), .readout_done(done2));

  // SRAM models: one-cycle read latency
  always @(posedge clk) begin
    if (rd_en1) rdata1 <= mem1[addr1[0]];
    if (rd_en2) rdata2 <= mem2[addr2[1:0]];
  end

  wire          m_rd_en = sel ? rd_en2 : rd_en1;
  wire [AW-1:0] m_addr  = sel ? addr2  : addr1;
  wire          m_valid = sel ? valid2 : valid1;
  wire [DW-1:0] m_data  = sel ? data2  : data1;
  wire [AW-1:0] m_row   = sel ? row2   : row1;
  wire [CW-1:0] m_col   = sel ? col2   : col1;
  wire          m_last  = sel ? last2  : last1;
  wire          m_busy  = sel ? busy2  : busy1;
  wire          m_done  = sel ? done2  : done1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            row;
    int            col;
    bit            last;
  } elem_t;
  elem_t exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 ready=1 with exact timing, 1 toggle, 2 random, 3 long stall at row 0 col 2
  task automatic run_readout(input int mode, input int nrows, input int retrig_k);
    int k, rd_idx, xfers, total;
    bit stall, finished;
    logic [DW-1:0] h_data;
    logic [AW-1:0] h_row;
    logic [CW-1:0] h_col;
    logic h_last;
    logic [AS*DW-1:0] rowv;
    elem_t e;
    exp_q.delete();
    for (int r = 0; r < nrows; r++) begin
      rowv = sel ? mem2[r] : mem1[r];
      for (int c = 0; c < AS; c++) begin
        e.data = rowv[c*DW +: DW];
        e.row  = r;
        e.col  = c;
        e.last = (r == nrows - 1) && (c == AS - 1);
        exp_q.push_back(e);
      end
    end
    total = nrows * AS;
    check("idle_before", m_busy, 1'b0);
    if (sel) tpu_done2 = 1'b1; else tpu_done1 = 1'b1;
    k = 0; rd_idx = 0; xfers = 0; stall = 1'b0; finished = 1'b0;
    h_data = '0; h_row = '0; h_col = '0; h_last = 1'b0;
    while (!finished && k < 600) begin
      step();
      k++;
      tpu_done1 = 1'b0;
      tpu_done2 = 1'b0;
      if (k == retrig_k) begin
        if (sel) tpu_done2 = 1'b1; else tpu_done1 = 1'b1;
      end
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (k % 2 == 0);
        2: out_ready = ($urandom_range(0, 2) != 0);
        3: out_ready = !(k >= 5 && k < 25);
        default: out_ready = 1'b1;
      endcase
      if (mode == 0) begin
        check("t_valid", m_valid, (k >= 3) && ((k - 3) % (AS + 2) < AS) && (k < (AS + 2) * nrows + 1));
        check("t_rd_en", m_rd_en, ((k - 1) % (AS + 2) == 0) && (k < (AS + 2) * nrows));
        check("t_done", m_done, k == (AS + 2) * nrows + 1);
        check("t_busy", m_busy, 1'b1);
      end
      if (m_rd_en) begin
        check("rd_addr", m_addr, rd_idx);
        rd_idx++;
      end
      if (stall) begin
        check("stall_valid", m_valid, 1'b1);
        check("stall_data", m_data, h_data);
        check("stall_row", m_row, h_row);
        check("stall_col", m_col, h_col);
        check("stall_last", m_last, h_last);
      end
      if (m_valid) begin
        if (xfers < total) begin
          check("data", m_data, exp_q[xfers].data);
          check("row", m_row, exp_q[xfers].row);
          check("col", m_col, exp_q[xfers].col);
          check("last", m_last, exp_q[xfers].last);
        end else begin
          check("extra_valid", m_valid, 1'b0);
        end
        if (out_ready) xfers++;
      end else begin
        check("last_idle", m_last, 1'b0);
      end
      stall = m_valid && !out_ready;
      h_data = m_data; h_row = m_row; h_col = m_col; h_last = m_last;
      if (m_done) begin
        check("done_count", xfers, total);
        check("done_rows", rd_idx, nrows);
        step();
        k++;
        check("busy_after", m_busy, 1'b0);
        check("done_pulse", m_done, 1'b0);
        check("valid_after", m_valid, 1'b0);
        finished = 1'b1;
      end
    end
    if (!finished) check("timeout", finished, 1'b1);
  endtask

  initial begin
    srst = 1'b1; tpu_done1 = 1'b0; tpu_done2 = 1'b0; out_ready = 1'b0; sel = 1'b0;
    mem1[0] = 64'h0004_0003_0002_0001;
    mem1[1] = 64'h0008_0007_0006_0005;
    for (int i = 0; i < 4; i++) mem2[i] = {$urandom, $urandom};
    step(); step(); step();
    check("rst_busy", {busy1, busy2}, 2'b00);
    check("rst_valid", {valid1, valid2}, 2'b00);
    check("rst_rd_en", {rd_en1, rd_en2}, 2'b00);
    check("rst_addr", {addr1, addr2}, 14'd0);
    check("rst_data", {data1, data2}, 32'd0);
    check("rst_rowcol", {row1, col1, row2, col2}, 18'd0);
    check("rst_last_done", {last1, last2, done1, done2}, 4'b0000);
    srst = 1'b0;
    step();

    // Scenario 1: fixed data, ready always high, exact timing
    run_readout(0, 2, 0);
    step();
    // Scenario 2: toggling ready
    run_readout(1, 2, 0);
    step();
    // Scenario 3: 20-cycle stall at row 0 col 2
    run_readout(3, 2, 0);
    step();
    // Scenario 4: retrigger while busy is ignored
    run_readout(0, 2, 5);
    step();

    // Scenario 5: synchronous reset mid-readout
    tpu_done1 = 1'b1;
    out_ready = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      tpu_done1 = 1'b0;
    end
    srst = 1'b1;
    step();
    check("abort_busy", busy1, 1'b0);
    check("abort_valid", valid1, 1'b0);
    check("abort_addr", addr1, 7'd0);
    srst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      check("abort_no_done", done1, 1'b0);
    end
    run_readout(0, 2, 0);
    step();

    // Random data and random ready on the 2-row instance
    for (int i = 0; i < 2; i++) mem1[i] = {$urandom, $urandom};
    run_readout(2, 2, 0);
    step();

    // Scenario 6: four rows on the DATA_SET=2 instance
    sel = 1'b1;
    run_readout(0, 4, 0);
    step();
    for (int i = 0; i < 4; i++) mem2[i] = {$urandom, $urandom};
    run_readout(2, 4, 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
